// File: rtl/i_mem_prefetch_pkg.sv
// i_mem_prefetch_pkg: state encoding shared by the prefetching instruction memory
package i_mem_prefetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PREF  = 2'd2
  } state_e;
endpackage

// File: rtl/i_mem_bram_sp.sv
// i_mem_bram_sp: single-port read-first synchronous RAM; vendor macros drop in here
module i_mem_bram_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) mem_q[addr_i] <= wdata_i;
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/i_mem_prefetch.sv
// i_mem_prefetch: instruction memory with a one-entry sequential prefetch buffer,
// a run-time load port and a saturating prefetch-hit counter
module i_mem_prefetch
  import i_mem_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 1024,
  parameter int PREFETCH_EN = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic [CNT_WIDTH-1:0]  hit_count
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  state_e                state_q, state_d;
  logic                  issued_q, issued_d, oor_q, oor_d, pf_valid_q, pf_valid_d, busy_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, pf_addr_q, pf_addr_d, pf_base, pf_nxt;
  logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d, ram_rdata, rd_data;
  logic [CNT_WIDTH-1:0]  hit_q;
  logic                  ack, hit, do_pf, do_dem, retry, to_idle, pf_ok, rd_req, ld_ok, ld_pf;

  assign ld_ok = ld_we && in_rng(ld_addr);
  assign ld_pf = ld_ok && ld_addr == pf_addr_q;

  always_comb begin
    ack = 1'b0;
    rd_data = '0;
    hit = 1'b0;
    do_pf = 1'b0;
    do_dem = 1'b0;
    retry = 1'b0;
    to_idle = 1'b0;
    pf_base = pf_addr_q;
    pf_valid_d = pf_valid_q;
    pf_data_d = pf_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_req && pf_valid_q && i_addr == pf_addr_q && !ld_pf) begin
          ack = 1'b1;
          rd_data = pf_data_q;
          hit = 1'b1;
          do_pf = 1'b1;
        end else do_dem = i_req;
      end
      S_FETCH: begin
        if (issued_q || oor_q) begin
          ack = 1'b1;
          rd_data = oor_q ? '0 : ram_rdata;
          do_pf = 1'b1;
          pf_base = rd_addr_q;
        end else retry = 1'b1;
      end
      S_PREF: begin
        if (!issued_q) retry = 1'b1;
        else begin
          pf_data_d = ram_rdata;
          pf_valid_d = 1'b1;
          if (i_req && !ld_pf && i_addr == pf_addr_q) begin
            ack = 1'b1;
            rd_data = ram_rdata;
            hit = 1'b1;
            do_pf = 1'b1;
          end else if (i_req) begin
            pf_valid_d = 1'b0;
            do_dem = 1'b1;
          end else to_idle = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase
    // a load hitting the buffered address (or the one arriving now) invalidates it
    if (ld_pf) pf_valid_d = 1'b0;
    pf_nxt = pf_base + 1'b1;
    pf_ok = PREFETCH_EN != 0 && pf_nxt != '0 && in_rng(pf_nxt);
    state_d = state_q;
    rd_addr_d = rd_addr_q;
    pf_addr_d = pf_addr_q;
    oor_d = oor_q;
    rd_req = retry;
    if (do_pf && pf_ok) begin
      state_d = S_PREF;
      rd_addr_d = pf_nxt;
      pf_addr_d = pf_nxt;
      pf_valid_d = 1'b0;
      oor_d = 1'b0;
      rd_req = 1'b1;
    end else if (do_pf || to_idle) state_d = S_IDLE;
    if (do_dem) begin
      state_d = S_FETCH;
      rd_addr_d = i_addr;
      oor_d = !in_rng(i_addr);
      rd_req = in_rng(i_addr);
    end
    // the load port owns the RAM this cycle; a blocked read retries next cycle
    issued_d = rd_req && !ld_ok;
  end

  i_mem_bram_sp #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH), .AW(IW)) u_ram (
    .clk     (clk),
    .en_i    (ld_ok || rd_req),
    .we_i    (ld_ok),
    .addr_i  (ld_ok ? ld_addr[IW-1:0] : rd_addr_d[IW-1:0]),
    .wdata_i (ld_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issued_q <= 1'b0;
      oor_q <= 1'b0;
      pf_valid_q <= 1'b0;
      rd_addr_q <= '0;
      pf_addr_q <= '0;
      pf_data_q <= '0;
      hit_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      oor_q <= oor_d;
      pf_valid_q <= pf_valid_d;
      rd_addr_q <= rd_addr_d;
      pf_addr_q <= pf_addr_d;
      pf_data_q <= pf_data_d;
      hit_q <= (hit && ~&hit_q) ? hit_q + 1'b1 : hit_q;
      busy_q <= i_req && !i_ack;
    end
  end

  assign i_ack = ack && !rst;
  assign i_rdata = i_ack ? rd_data : '0;
  assign hit_count = hit_q;

  a_req_held: assert property (@(posedge clk) disable iff (rst) busy_q |-> i_req);
endmodule
